// File: rtl/agc_timer_pkg.sv
// Shared constants and types for the parametrised timer bank.
package agc_timer_pkg;

   // Bus data path width
   localparam int unsigned DATA_W = 16;

   // Register field selector, the low two address bits
   typedef enum logic [1:0] {
      FIELD_COUNT = 2'd0,
      FIELD_DIV   = 2'd1,
      FIELD_CTRL  = 2'd2,
      FIELD_PHASE = 2'd3
   } field_e;

   // Control register bit positions
   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IRQ_EN  = 1;
   localparam int unsigned CTRL_CASCADE = 2;
   localparam int unsigned CTRL_W       = 3;

   // Divisor loaded into every channel at reset
   localparam int unsigned DEFAULT_DIVISOR = 60000;

   // Channel indices that the old fixed TIME3..TIME6 logic occupied
   typedef enum logic [2:0] {
      LEGACY_T3 = 3'd2,
      LEGACY_T4 = 3'd3,
      LEGACY_T5 = 3'd4,
      LEGACY_T6 = 3'd5
   } legacy_chan_e;

   // Per-channel control register
   typedef struct packed {
      logic cascade;
      logic irq_en;
      logic enable;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{cascade: 1'b0, irq_en: 1'b1, enable: 1'b1};

endpackage

// File: rtl/agc_timer_channel.sv
// One timer channel: prescaler, counter, divisor and control registers.
// The tick itself is resolved by the bank so cascade chains stay in one place.
module agc_timer_channel
   import agc_timer_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH     = 15,
   parameter int unsigned DIV_WIDTH       = 16,
   parameter int unsigned DEFAULT_DIVISOR = agc_timer_pkg::DEFAULT_DIVISOR,
   parameter bit          CASCADE_OK      = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_count,
   input  logic                   wr_div,
   input  logic                   wr_ctrl,
   input  logic                   wr_phase,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   tick,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [DIV_WIDTH-1:0]   divisor,
   output ctrl_t                  ctrl,
   output logic [DIV_WIDTH-1:0]   prescaler,
   output logic                   own_tick_c,
   output logic                   chain_c,
   output logic                   at_max_c
);

   localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIVISOR);

   logic [DIV_WIDTH-1:0] limit_c;
   logic                 cascaded_c;

   // Prescaler wrap point (divisor 0 acts as 1) and tick sources
   always_comb begin
      limit_c    = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
      cascaded_c = CASCADE_OK && ctrl.cascade;
      own_tick_c = ctrl.enable && !cascaded_c && (prescaler == limit_c);
      chain_c    = ctrl.enable && cascaded_c;
      at_max_c   = (count == '1);
   end

   // Prescaler: bus load wins, frozen while cascaded or disabled
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
      end else if (wr_phase) begin
         prescaler <= DIV_WIDTH'(wr_data);
      end else if (ctrl.enable && !cascaded_c) begin
         prescaler <= (prescaler == limit_c) ? '0 : prescaler + DIV_WIDTH'(1);
      end
   end

   // Counter: bus load wins over a tick, natural wrap on overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= COUNT_WIDTH'(wr_data);
      end else if (tick) begin
         count <= count + COUNT_WIDTH'(1);
      end
   end

   // Divisor register
   always_ff @(posedge clk) begin
      if (reset) begin
         divisor <= DIV_RESET;
      end else if (wr_div) begin
         divisor <= DIV_WIDTH'(wr_data);
      end
   end

   // Control register
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl <= CTRL_RESET;
      end else if (wr_ctrl) begin
         ctrl <= '{cascade: wr_data[CTRL_CASCADE],
                   irq_en:  wr_data[CTRL_IRQ_EN],
                   enable:  wr_data[CTRL_EN]};
      end
   end

endmodule

// File: rtl/agc_timer_bank.sv
// Register-mapped bank of timer channels with overflow flags and a
// fixed-priority interrupt request.
module agc_timer_bank #(
   parameter int unsigned NUM_TIMERS      = 6,
   parameter int unsigned COUNT_WIDTH     = 15,
   parameter int unsigned DIV_WIDTH       = 16,
   parameter int unsigned DEFAULT_DIVISOR = agc_timer_pkg::DEFAULT_DIVISOR,
   parameter int unsigned ADDR_WIDTH      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bus_enable,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [15:0]           data_in,
   output logic [15:0]           data_out,
   input  logic                  interrupt_enable,
   input  logic [NUM_TIMERS-1:0] interrupt_clear,
   output logic [NUM_TIMERS-1:0] interrupt_flags,
   output logic                  irq_request,
   output logic [2:0]            irq_vector,
   input  logic                  irq_ack
);

   import agc_timer_pkg::*;

   localparam int unsigned CHAN_W = ADDR_WIDTH - 2;

   logic [CHAN_W-1:0]      chan_c;
   field_e                 field_c;
   logic                   wr_c;
   logic                   rd_c;
   logic [NUM_TIMERS-1:0]  wr_count_c;
   logic [NUM_TIMERS-1:0]  wr_div_c;
   logic [NUM_TIMERS-1:0]  wr_ctrl_c;
   logic [NUM_TIMERS-1:0]  wr_phase_c;
   logic [NUM_TIMERS-1:0]  own_tick_c;
   logic [NUM_TIMERS-1:0]  chain_c;
   logic [NUM_TIMERS-1:0]  at_max_c;
   logic [NUM_TIMERS-1:0]  tick_c;
   logic [NUM_TIMERS-1:0]  ovf_c;
   logic [NUM_TIMERS-1:0]  flags_d_c;
   logic [DATA_W-1:0]      rd_data_c;
   logic                   carry_c;

   logic [COUNT_WIDTH-1:0] count_q     [NUM_TIMERS];
   logic [DIV_WIDTH-1:0]   divisor_q   [NUM_TIMERS];
   ctrl_t                  ctrl_q      [NUM_TIMERS];
   logic [DIV_WIDTH-1:0]   prescaler_q [NUM_TIMERS];

   // Address split and access qualifiers
   always_comb begin
      chan_c  = address[ADDR_WIDTH-1:2];
      field_c = field_e'(address[1:0]);
      wr_c    = bus_enable && write_enable;
      rd_c    = bus_enable && !write_enable;
   end

   // Per-channel write strobes
   always_comb begin
      wr_count_c = '0;
      wr_div_c   = '0;
      wr_ctrl_c  = '0;
      wr_phase_c = '0;
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         if (wr_c && (chan_c == CHAN_W'(i))) begin
            wr_count_c[i] = (field_c == FIELD_COUNT);
            wr_div_c[i]   = (field_c == FIELD_DIV);
            wr_ctrl_c[i]  = (field_c == FIELD_CTRL);
            wr_phase_c[i] = (field_c == FIELD_PHASE);
         end
      end
   end

   // Tick resolution: cascade chains ripple upward within the cycle, and a
   // counter or prescaler write swallows that channel's tick
   always_comb begin
      tick_c  = '0;
      ovf_c   = '0;
      carry_c = 1'b0;
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         tick_c[i] = (own_tick_c[i] || (chain_c[i] && carry_c))
                     && !wr_count_c[i] && !wr_phase_c[i];
         ovf_c[i]  = tick_c[i] && at_max_c[i];
         carry_c   = ovf_c[i];
      end
   end

   for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
      agc_timer_channel #(
         .COUNT_WIDTH     (COUNT_WIDTH),
         .DIV_WIDTH       (DIV_WIDTH),
         .DEFAULT_DIVISOR (DEFAULT_DIVISOR),
         .CASCADE_OK      (g != 0)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .wr_count   (wr_count_c[g]),
         .wr_div     (wr_div_c[g]),
         .wr_ctrl    (wr_ctrl_c[g]),
         .wr_phase   (wr_phase_c[g]),
         .wr_data    (data_in),
         .tick       (tick_c[g]),
         .count      (count_q[g]),
         .divisor    (divisor_q[g]),
         .ctrl       (ctrl_q[g]),
         .prescaler  (prescaler_q[g]),
         .own_tick_c (own_tick_c[g]),
         .chain_c    (chain_c[g]),
         .at_max_c   (at_max_c[g])
      );
   end

   // Read mux; the slot after the last channel exposes the flag register
   always_comb begin
      rd_data_c = '0;
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         if (chan_c == CHAN_W'(i)) begin
            case (field_c)
               FIELD_COUNT: rd_data_c = DATA_W'(count_q[i]);
               FIELD_DIV:   rd_data_c = DATA_W'(divisor_q[i]);
               FIELD_CTRL:  rd_data_c = DATA_W'(ctrl_q[i]);
               FIELD_PHASE: rd_data_c = DATA_W'(prescaler_q[i]);
               default:     rd_data_c = '0;
            endcase
         end
      end
      if ((chan_c == CHAN_W'(NUM_TIMERS)) && (field_c == FIELD_COUNT)) begin
         rd_data_c = DATA_W'(interrupt_flags);
      end
   end

   // Registered read data, held between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= '0;
      end else if (rd_c) begin
         data_out <= rd_data_c;
      end
   end

   // Lowest pending channel wins the vector
   always_comb begin
      irq_vector = '0;
      for (int i = int'(NUM_TIMERS) - 1; i >= 0; i--) begin
         if (interrupt_flags[i]) begin
            irq_vector = 3'(i);
         end
      end
      irq_request = (|interrupt_flags) && interrupt_enable;
   end

   // Flag next state: a new overflow beats any clear in the same cycle
   always_comb begin
      flags_d_c = '0;
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         flags_d_c[i] = (ovf_c[i] && interrupt_enable && ctrl_q[i].irq_en)
                        || (interrupt_flags[i] && !interrupt_clear[i]
                            && !(irq_ack && irq_request && (irq_vector == 3'(i))));
      end
   end

   // Pending flag register
   always_ff @(posedge clk) begin
      if (reset) begin
         interrupt_flags <= '0;
      end else begin
         interrupt_flags <= flags_d_c;
      end
   end

endmodule

// File: tb/tb_agc_timer_bank.sv
// Self-checking bench for agc_timer_bank: reference model compared every
// cycle, table-driven register checks and directed corner-case sequences.
module tb_agc_timer_bank;

   localparam int NT = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          bus_enable;
   logic          write_enable;
   logic [4:0]    address;
   logic [15:0]   data_in;
   logic [15:0]   data_out;
   logic          interrupt_enable;
   logic [NT-1:0] interrupt_clear;
   logic [NT-1:0] interrupt_flags;
   logic          irq_request;
   logic [2:0]    irq_vector;
   logic          irq_ack;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int unsigned m_cnt [NT];
   int unsigned m_div [NT];
   int unsigned m_pre [NT];
   bit [2:0]    m_ctrl[NT];
   bit [NT-1:0] m_flags;
   bit [15:0]   m_dout;

   typedef struct {
      string       name;
      int          ch;
      int          f;
      bit          wr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];

   agc_timer_bank dut (
      .clk              (clk),
      .reset            (reset),
      .bus_enable       (bus_enable),
      .write_enable     (write_enable),
      .address          (address),
      .data_in          (data_in),
      .data_out         (data_out),
      .interrupt_enable (interrupt_enable),
      .interrupt_clear  (interrupt_clear),
      .interrupt_flags  (interrupt_flags),
      .irq_request      (irq_request),
      .irq_vector       (irq_vector),
      .irq_ack          (irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         m_cnt[i]  = 0;
         m_pre[i]  = 0;
         m_div[i]  = 60000;
         m_ctrl[i] = 3'b011;
      end
      m_flags = '0;
      m_dout  = '0;
   endtask

   function automatic int model_vec();
      for (int i = 0; i < NT; i++) if (m_flags[i]) return i;
      return 0;
   endfunction

   function automatic bit model_req();
      return (m_flags != 0) && interrupt_enable;
   endfunction

   function automatic bit [15:0] model_read(input int ch, input int f);
      if (ch < NT) begin
         case (f)
            0: return 16'(m_cnt[ch]);
            1: return 16'(m_div[ch]);
            2: return 16'(m_ctrl[ch]);
            default: return 16'(m_pre[ch]);
         endcase
      end
      if (ch == NT && f == 0) return 16'(m_flags);
      return 16'h0000;
   endfunction

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      int ch, f, vec;
      bit wr, rd, carry, req;
      bit [NT-1:0] nflags;
      ch = int'(address) / 4;
      f  = int'(address) % 4;
      wr = bus_enable && write_enable;
      rd = bus_enable && !write_enable;
      if (reset) begin
         model_reset();
         return;
      end
      req = model_req();
      vec = model_vec();
      if (rd) m_dout = model_read(ch, f);
      carry = 1'b0;
      for (int i = 0; i < NT; i++) begin
         bit en, casc, tick, ovf, wc, wp, wd, wk;
         int unsigned period, np, nc;
         en     = m_ctrl[i][0];
         casc   = (i > 0) && m_ctrl[i][2];
         period = (m_div[i] == 0) ? 1 : m_div[i];
         tick   = 1'b0;
         np     = m_pre[i];
         if (en && casc) begin
            tick = carry;
         end else if (en) begin
            if (m_pre[i] == period - 1) begin
               tick = 1'b1;
               np   = 0;
            end else begin
               np = (m_pre[i] + 1) % 65536;
            end
         end
         wc = wr && ch == i && f == 0;
         wd = wr && ch == i && f == 1;
         wk = wr && ch == i && f == 2;
         wp = wr && ch == i && f == 3;
         if (wp) np = data_in;
         if (wc || wp) tick = 1'b0;
         ovf = 1'b0;
         nc  = m_cnt[i];
         if (wc) nc = data_in % 32768;
         else if (tick) begin
            if (m_cnt[i] == 32767) begin
               nc  = 0;
               ovf = 1'b1;
            end else begin
               nc = m_cnt[i] + 1;
            end
         end
         carry = ovf;
         nflags[i] = (ovf && interrupt_enable && m_ctrl[i][1]) ||
                     (m_flags[i] && !(interrupt_clear[i] || (irq_ack && req && vec == i)));
         m_cnt[i] = nc;
         m_pre[i] = np;
         if (wd) m_div[i] = data_in;
         if (wk) m_ctrl[i] = data_in[2:0];
      end
      m_flags = nflags;
   endtask

   task automatic compare_model();
      check("data_out", 32'(data_out), 32'(m_dout));
      check("flags", 32'(interrupt_flags), 32'(m_flags));
      check("irq_request", 32'(irq_request), 32'(model_req()));
      check("irq_vector", 32'(irq_vector), 32'(model_vec()));
   endtask

   // One clock: compare mid-cycle, step model, then settle after the edge
   task automatic cyc();
      @(negedge clk);
      compare_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic bus_write(input int ch, input int f, input logic [15:0] d);
      bus_enable   = 1'b1;
      write_enable = 1'b1;
      address      = 5'(ch * 4 + f);
      data_in      = d;
      cyc();
      bus_enable   = 1'b0;
      write_enable = 1'b0;
   endtask

   task automatic rd_check(input string name, input int ch, input int f, input logic [15:0] exp);
      bus_enable   = 1'b1;
      write_enable = 1'b0;
      address      = 5'(ch * 4 + f);
      cyc();
      bus_enable   = 1'b0;
      check(name, 32'(data_out), 32'(exp));
   endtask

   initial begin
      reset            = 1'b1;
      bus_enable       = 1'b0;
      write_enable     = 1'b0;
      address          = '0;
      data_in          = '0;
      interrupt_enable = 1'b1;
      interrupt_clear  = '0;
      irq_ack          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;
      check("reset_data_out", 32'(data_out), 32'h0);
      check("reset_flags", 32'(interrupt_flags), 32'h0);
      check("reset_irq_request", 32'(irq_request), 32'h0);
      check("reset_irq_vector", 32'(irq_vector), 32'h0);

      // Register map vectors
      tbl.push_back('{"rst_cnt0",     0, 0, 1'b0, 16'h0000, 16'h0000});
      tbl.push_back('{"rst_div5",     5, 1, 1'b0, 16'h0000, 16'd60000});
      tbl.push_back('{"rst_ctrl3",    3, 2, 1'b0, 16'h0000, 16'h0003});
      tbl.push_back('{"flag_slot",    6, 0, 1'b0, 16'h0000, 16'h0000});
      tbl.push_back('{"slot6_f1",     6, 1, 1'b0, 16'h0000, 16'h0000});
      tbl.push_back('{"chan7_f0",     7, 0, 1'b0, 16'h0000, 16'h0000});
      tbl.push_back('{"ctrl5_mask",   5, 2, 1'b1, 16'hFFF8, 16'h0000});
      tbl.push_back('{"cnt5_trunc",   5, 0, 1'b1, 16'hFFFF, 16'h7FFF});
      tbl.push_back('{"phase5",       5, 3, 1'b1, 16'h00AB, 16'h00AB});
      tbl.push_back('{"div5_zero",    5, 1, 1'b1, 16'h0000, 16'h0000});
      tbl.push_back('{"slot6_wr_ign", 6, 0, 1'b1, 16'hFFFF, 16'h0000});
      tbl.push_back('{"chan7_wr_ign", 7, 2, 1'b1, 16'h1234, 16'h0000});
      tbl.push_back('{"ctrl5_irqen",  5, 2, 1'b1, 16'h0002, 16'h0002});
      foreach (tbl[k]) begin
         if (tbl[k].wr) bus_write(tbl[k].ch, tbl[k].f, tbl[k].wdata);
         rd_check(tbl[k].name, tbl[k].ch, tbl[k].f, tbl[k].exp);
      end

      // Divisor 3 for 12 cycles gives four ticks
      bus_write(0, 2, 16'h0000);
      bus_write(0, 0, 16'h0000);
      bus_write(0, 3, 16'h0000);
      bus_write(0, 1, 16'h0003);
      bus_write(0, 2, 16'h0003);
      idle(12);
      rd_check("div3_count", 0, 0, 16'h0004);

      // Overflow sets flag, ack clears it
      bus_write(0, 2, 16'h0000);
      bus_write(0, 0, 16'h7FFF);
      bus_write(0, 1, 16'h0001);
      bus_write(0, 3, 16'h0000);
      bus_write(0, 2, 16'h0003);
      idle(1);
      check("ovf_flags", 32'(interrupt_flags), 32'h01);
      check("ovf_req", 32'(irq_request), 32'h1);
      check("ovf_vec", 32'(irq_vector), 32'h0);
      rd_check("ovf_cnt0", 0, 0, 16'h0000);
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      check("ack_clear", 32'(interrupt_flags), 32'h00);

      // Cascade: channel 1 ticks on channel 0 overflow, prescaler frozen
      bus_write(0, 2, 16'h0000);
      bus_write(0, 0, 16'h7FFE);
      bus_write(0, 3, 16'h0000);
      bus_write(1, 2, 16'h0007);
      bus_write(1, 3, 16'h0100);
      bus_write(1, 0, 16'h0005);
      bus_write(0, 2, 16'h0003);
      idle(2);
      check("casc_flags", 32'(interrupt_flags), 32'h01);
      rd_check("casc_cnt0", 0, 0, 16'h0000);
      rd_check("casc_cnt1", 1, 0, 16'h0006);
      rd_check("casc_phase1", 1, 3, 16'h0100);
      bus_write(0, 2, 16'h0000);
      bus_write(1, 2, 16'h0000);
      interrupt_clear = 6'b000001;
      cyc();
      interrupt_clear = '0;
      check("casc_clear", 32'(interrupt_flags), 32'h00);

      // Priority, ack advance, set beats clear
      bus_write(2, 2, 16'h0000);
      bus_write(4, 2, 16'h0000);
      bus_write(2, 1, 16'h0001);
      bus_write(4, 1, 16'h0001);
      bus_write(2, 3, 16'h0000);
      bus_write(4, 3, 16'h0000);
      bus_write(2, 0, 16'h7FFF);
      bus_write(4, 0, 16'h7FFF);
      bus_write(2, 2, 16'h0003);
      bus_write(4, 2, 16'h0003);
      idle(1);
      check("prio_flags", 32'(interrupt_flags), 32'h14);
      check("prio_vec2", 32'(irq_vector), 32'h2);
      check("prio_req", 32'(irq_request), 32'h1);
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      check("prio_vec4", 32'(irq_vector), 32'h4);
      check("prio_flags4", 32'(interrupt_flags), 32'h10);
      bus_write(4, 0, 16'h7FFF);
      interrupt_clear = 6'b010000;
      cyc();
      check("set_beats_clear", 32'(interrupt_flags), 32'h10);
      cyc();
      interrupt_clear = '0;
      check("clear4", 32'(interrupt_flags), 32'h00);
      bus_write(2, 2, 16'h0000);
      bus_write(4, 2, 16'h0000);

      // Counter write beats tick; phase load lands two cycles before a tick
      bus_write(3, 1, 16'h0001);
      bus_write(3, 3, 16'h0000);
      bus_write(3, 0, 16'h0010);
      rd_check("wr_beats_tick", 3, 0, 16'h0010);
      bus_write(3, 2, 16'h0000);
      bus_write(3, 1, 16'd60000);
      bus_write(3, 3, 16'h0000);
      bus_write(3, 0, 16'h0000);
      bus_write(3, 2, 16'h0001);
      bus_write(3, 3, 16'd59998);
      rd_check("phase_t1", 3, 0, 16'h0000);
      rd_check("phase_t2", 3, 0, 16'h0000);
      rd_check("phase_t3", 3, 0, 16'h0001);

      // Reset mid-operation with a read in flight
      rd_check("pre_rst_div3", 3, 1, 16'd60000);
      reset        = 1'b1;
      bus_enable   = 1'b1;
      write_enable = 1'b0;
      address      = 5'(2 * 4 + 1);
      cyc();
      reset      = 1'b0;
      bus_enable = 1'b0;
      check("rst_mid_dout", 32'(data_out), 32'h0);
      rd_check("rst_mid_cnt2", 2, 0, 16'h0000);
      rd_check("rst_mid_div2", 2, 1, 16'd60000);
      rd_check("rst_mid_ctrl2", 2, 2, 16'h0003);
      rd_check("rst_mid_cnt3", 3, 0, 16'h0000);
      rd_check("slot6_f2", 6, 2, 16'h0000);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int op, ch, f;
         op = int'($urandom_range(0, 9));
         ch = int'($urandom_range(0, 7));
         f  = int'($urandom_range(0, 3));
         reset        = ($urandom_range(0, 599) == 0);
         bus_enable   = (op < 7);
         write_enable = (op < 4);
         address      = 5'(ch * 4 + f);
         case (f)
            0:       data_in = ($urandom_range(0, 1) == 1) ? 16'(16'h7FF0 + $urandom_range(0, 15)) : 16'($urandom);
            1:       data_in = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            2:       data_in = 16'($urandom);
            default: data_in = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 4)) : 16'($urandom);
         endcase
         interrupt_enable = ($urandom_range(0, 9) != 0);
         interrupt_clear  = ($urandom_range(0, 7) == 0) ? NT'($urandom) : '0;
         irq_ack          = ($urandom_range(0, 5) == 0);
         cyc();
      end
      reset           = 1'b0;
      bus_enable      = 1'b0;
      write_enable    = 1'b0;
      interrupt_clear = '0;
      irq_ack         = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/agc_timer_bank.md
Name: agc_timer_bank

Overview:
- Parametrised successor to the fixed TIME1–TIME6 logic. Provides NUM_TIMERS free-running counters.
- Each channel has its own prescaler divisor, prescaler phase, enable, interrupt-enable and cascade mode.
- Channels are register-mapped for the CPU bus. Overflow sets per-channel pending flags, which feed a fixed-priority interrupt request with an acknowledge handshake.
- Sits beside the memory router; the router forwards timer-window reads and writes here.

Parameters:
- NUM_TIMERS, 6, number of channels (1..8).
- COUNT_WIDTH, 15, counter width in bits (≤16).
- DIV_WIDTH, 16, prescaler divisor and prescaler counter width.
- DEFAULT_DIVISOR, 60000, divisor loaded into every channel at reset.
- ADDR_WIDTH, 5, bus address width; must be ≥ clog2(NUM_TIMERS+1)+2.

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- bus_enable  in  1  bus access strobe
- write_enable  in  1  1 = write, 0 = read (qualified by bus_enable)
- address  in  ADDR_WIDTH  {channel, field[1:0]}
- data_in  in  16  write data
- data_out  out  16  registered read data
- interrupt_enable  in  1  global interrupt gate
- interrupt_clear  in  NUM_TIMERS  per-channel flag clear (level)
- interrupt_flags  out  NUM_TIMERS  pending overflow flags
- irq_request  out  1  any flag pending and interrupt_enable=1
- irq_vector  out  3  index of the lowest-numbered pending channel
- irq_ack  in  1  one-cycle pulse; clears the flag named by irq_vector

Behaviour:

Reset:
- Reset is synchronous and active-high on clk.
- All counters = 0; prescaler counters = 0; divisors = DEFAULT_DIVISOR.
- ctrl = {cascade=0, irq_en=1, enable=1}.
- interrupt_flags = 0; data_out = 0; irq_request = 0; irq_vector = 0.

Register map (address = {chan, field}, chan < NUM_TIMERS):
- field 0: counter (R/W, zero-extended on read).
- field 1: divisor (R/W).
- field 2: ctrl; bit0 enable, bit1 irq_en, bit2 cascade (R/W, other bits read 0).
- field 3: prescaler phase (write loads the prescaler counter, read returns it).
- chan == NUM_TIMERS, field 0: read returns interrupt_flags zero-extended; writes are ignored.
- All other addresses: reads return 0, writes are ignored.

Read timing:
- data_out is registered: valid the cycle after bus_enable & !write_enable.
- data_out holds its value when there is no read.

Tick generation (per channel, enable=1, cascade=0):
- When prescaler == max(divisor,1)-1: prescaler <= 0 and tick=1.
- Otherwise prescaler increments.
- Divisor 0 behaves as 1, i.e. a tick every cycle.
- A divisor written below the current prescaler value: the prescaler continues to wrap at 2^DIV_WIDTH, then obeys the new divisor. No forced reload.

Cascade:
- Channel i>0 with cascade=1 ticks in the same cycle that channel i-1 overflows. Its own prescaler is frozen.
- cascade is ignored on channel 0.
- Chains propagate combinationally within one cycle.

Count and overflow:
- On tick, counter increments.
- When the counter is all-ones it wraps to 0 and overflow=1.
- On overflow, the flag is set if interrupt_enable & irq_en. Overflow still propagates to a cascade successor regardless of irq_en.

enable=0:
- Prescaler and counter hold.
- The channel still accepts writes.
- It still forwards nothing to its cascade successor.

Simultaneous events:
- A bus write to a counter or prescaler in the same cycle as a tick: the write wins and the tick is lost. No overflow is raised from the overwritten value.
- Flag set and clear (interrupt_clear or irq_ack) in the same cycle: set wins, so no event is lost.
- irq_ack while irq_request=0 is ignored.

Interrupt outputs:
- irq_vector and irq_request are combinational from the registered flags and interrupt_enable.
- Fixed priority: lowest index wins.

Reset mid-operation:
- Reset in any cycle overrides all bus and tick activity that cycle.

Decomposition:
- Shared package agc_timer_pkg holds:
  - field codes FIELD_COUNT=0, FIELD_DIV=1, FIELD_CTRL=2, FIELD_PHASE=3;
  - ctrl bit indices CTRL_EN=0, CTRL_IRQ_EN=1, CTRL_CASCADE=2;
  - DEFAULT_DIVISOR;
  - the T3/T4/T5/T6 legacy channel indices.
- One sub-module, agc_timer_channel (prescaler, counter, overflow, write-override), instantiated NUM_TIMERS times via generate.
- The bank adds the address decode, read mux, flag register and priority encoder.

Test Plan:
1. Reset, then divisor0=3 and ctrl0=3; run 12 cycles → counter0 reads 4, with read data appearing one cycle after the read strobe.
2. counter0=0x7FFF, divisor0=1, interrupt_enable=1 → next cycle counter0=0, interrupt_flags[0]=1, irq_request=1, irq_vector=0; irq_ack pulse → flag cleared.
3. ctrl1=7 (cascade) with channel 0 at 0x7FFE, divisor 1 → after 2 cycles counter1 increments by 1 and counter0=0; channel 1 prescaler register is unchanged.
4. Flags 2 and 4 pending → irq_vector=2; ack → irq_vector=4; interrupt_clear[4] in the same cycle as a new channel-4 overflow → flag 4 stays 1.
5. Write counter3=0x0010 in the same cycle as its tick → reads 0x0010, not 0x0011; write phase3=59998 with divisor 60000 → tick 2 cycles later.
6. Assert reset mid-count with a read pending → data_out=0, all counters=0, divisors=60000 the next cycle; address chan=NUM_TIMERS field 2 reads 0.
